// File: rtl/mem_pkg.sv
// Shared definitions for the data-port memory responder.
//   state_t     : responder FSM state encoding
//   WORD_W      : data word width in bits
//   BYTE_OFF_W  : number of byte-offset bits below the word index
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed RAM backing the data-port responder.
// Synchronous write, asynchronous read, no reset of contents.
// Ports:
//   clk    : clock, write occurs on rising edge when we=1
//   we     : write enable
//   addr   : word index, shared by read and write
//   wdata  : write data
//   rdata  : combinational read data at addr
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port. Accepts one word load/store
// at a time over valid/ready, waits WAIT_CYCLES extra cycles, then presents
// a response held until rsp_ready.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | req_ready=1, waiting for req_valid; captures the request
//   ST_WAIT | counting down wait states; commits store / samples load at 0
//   ST_RESP | rsp_valid=1, rsp_* held until rsp_ready
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake, req_write, req_addr (byte), req_wdata
//   rsp_valid/rsp_ready handshake, rsp_rdata, rsp_err
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write;
  logic [IDX_W-1:0]  cap_idx;
  logic [WORD_W-1:0] cap_wdata;
  logic              cap_err;

  logic              req_err;
  logic              commit;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // Misaligned, or any address bit above the RAM's word index is set.
  assign req_err = (req_addr[BYTE_OFF_W-1:0] != '0) ||
                   (req_addr[WORD_W-1:IDX_W+BYTE_OFF_W] != '0);

  // The counter holds the wait cycles still to go after the first WAIT
  // cycle, so the edge entering RESP is accept edge + 1 + WAIT_CYCLES.
  assign commit = (state == ST_WAIT) && (cnt == '0);
  assign mem_we = commit && cap_write && !cap_err;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_err   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_idx   <= req_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
            cap_wdata <= req_wdata;
            cap_err   <= req_err;
            cnt       <= CNT_W'(WAIT_CYCLES);
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            // Read sees RAM before this edge's write; stores return 0 anyway.
            rsp_valid <= 1'b1;
            rsp_err   <= cap_err;
            rsp_rdata <= (cap_err || cap_write) ? '0 : mem_rdata;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rr_mode = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  bit          have_cur = 0;
  logic [31:0] ref_mem [DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer readiness: 0 = held low, 1 = held high, otherwise random.
  always @(negedge clk) begin
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom);
    endcase
  end

  // Monitor: pops the expected response when one first appears, then checks
  // it stays stable and that no new request is accepted until it is consumed.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      have_cur = 0;
    end else if (rsp_valid) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          chk("latency", cyc, cur.exp_cyc);
          chk("rsp_rdata", rsp_rdata, cur.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
        end
      end else begin
        chk("rsp_rdata_stable", rsp_rdata, cur.rdata);
        chk("rsp_err_stable", {31'b0, rsp_err}, {31'b0, cur.err});
      end
      chk("req_ready_in_rsp", {31'b0, req_ready}, 32'd0);
      if (rsp_ready) have_cur = 0;
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input bit track);
    exp_t e;
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: req_ready=%0b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e.err = (a[1:0] != 2'b0) || (a[31:8] != 24'b0);
      e.rdata = 32'h0;
      if (!e.err) begin
        if (w) ref_mem[a[7:2]] = d;
        else   e.rdata = ref_mem[a[7:2]];
      end
      e.exp_cyc = cyc + 2 + W;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || have_cur) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || have_cur) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    int r;

    // 1: reset held with random request activity
    repeat (8) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      #2;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end

    // Fill RAM so every load has a known expected value
    rr_mode = 1;
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b1);
    issue(1'b1, 32'h8, 32'h0, 1'b1);

    // 2: store then load
    issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);

    // 3: misaligned accesses leave RAM untouched
    issue(1'b0, 32'h13, 32'h0, 1'b1);
    issue(1'b1, 32'h22, 32'hAAAA5555, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 1'b1);

    // 4: out of range and top word
    issue(1'b0, 32'h100, 32'h0, 1'b1);
    issue(1'b0, 32'hFC, 32'h0, 1'b1);
    drain();

    // 5: backpressure with an ignored request present
    rr_mode = 0;
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_arrived", {31'b0, rsp_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h0BAD0BAD;
      #2;
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rr_mode = 1;
    n = 0;
    while (rsp_valid && n < 10) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("bp_released_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_released_req_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 32'h10, 32'h0, 1'b1);
    drain();

    // 6: reset during WAIT of a store discards it
    issue(1'b1, 32'h8, 32'h12345678, 1'b0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #2;
      chk("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    issue(1'b0, 32'h8, 32'h0, 1'b1);
    drain();

    // Random traffic with random consumer readiness
    rr_mode = 2;
    repeat (150) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
      else             a = $urandom | 32'h8000_0000;
      issue(1'($urandom), a, $urandom, 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
